// File: rtl/mem_arbiter_ctrl_pkg.sv
// Shared types and constants for the IF/LS memory arbiter.
// Holds the access-length codes, R/W encodings, enable levels and the arbiter state set.
package mem_arbiter_ctrl_pkg;

  typedef enum logic [1:0] {
    LEN_BYTE = 2'b00,
    LEN_HALF = 2'b01,
    LEN_WORD = 2'b11
  } ls_len_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic EN  = 1'b1;
  localparam logic DIS = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    IF_RD,
    LS_RD,
    LS_WR
  } arb_state_e;

endpackage

// File: rtl/mem_byte_seq.sv
// Byte sequencer for one RAM access: base/offset addressing, byte counter,
// lane assembly of returned read bytes and last-address / last-capture detect.
module mem_byte_seq
  import mem_arbiter_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              step,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [1:0]        start_last,
  input  logic [7:0]        din,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        cnt,
  output logic              last_addr,
  output logic              last_cap,
  output logic [DATA_W-1:0] asm_data
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [1:0]        last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [2:0]        last_ext;
  logic [1:0]        lane;

  always_comb begin
    last_ext  = {1'b0, last_q};
    lane      = cnt_q[1:0] - 2'd1;
    last_addr = (cnt_q == last_ext);
    last_cap  = (cnt_q == last_ext + 3'd1);
    // Byte issued at count k returns while the count reads k+1.
    asm_data = data_q;
    if (cnt_q != 3'd0) asm_data[{lane, 3'b000} +: 8] = din;

    addr_d = addr_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    data_d = data_q;
    if (start) begin
      addr_d = start_addr;
      cnt_d  = '0;
      last_d = start_last;
      data_d = '0;
    end else if (abort) begin
      addr_d = '0;
      cnt_d  = '0;
    end else if (step) begin
      cnt_d  = cnt_q + 3'd1;
      data_d = asm_data;
      addr_d = (cnt_q < last_ext) ? addr_q + ADDR_W'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
      last_q <= '0;
      data_q <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
      data_q <= data_d;
    end
  end

  assign addr = addr_q;
  assign cnt  = cnt_q[1:0];

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Arbitrates the byte-wide RAM port between instruction fetch and load/store,
// LS having fixed priority; each access is sequenced byte by byte by mem_byte_seq.
module mem_arbiter_ctrl
  import mem_arbiter_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              ifEn,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic              ifOutEn,
  output logic [DATA_W-1:0] ifData,
  input  logic              dataEn,
  input  logic              LSRW,
  input  logic [ADDR_W-1:0] dataAddr,
  input  logic [1:0]        LSlen,
  input  logic [DATA_W-1:0] Sdata,
  output logic              LOutEn,
  output logic [DATA_W-1:0] Ldata,
  output logic              LSfree,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  arb_state_e state_q, state_d;

  logic              pend_if_q, pend_if_d, pend_ls_q, pend_ls_d;
  logic [ADDR_W-1:0] if_addr_q, if_addr_d, ls_addr_q, ls_addr_d;
  logic [1:0]        ls_len_q, ls_len_d;
  logic              ls_rw_q, ls_rw_d;
  logic [DATA_W-1:0] ls_data_q, ls_data_d;

  logic              if_out_en_q, if_out_en_d, l_out_en_q, l_out_en_d;
  logic [DATA_W-1:0] if_data_q, if_data_d, ldata_q, ldata_d;
  logic              ls_free_q, ls_free_d, mem_wr_q, mem_wr_d;
  logic [7:0]        mem_dout_q, mem_dout_d;

  logic              ls_accept, if_accept, ls_req, if_req, ls_in_flight;
  logic [ADDR_W-1:0] ls_addr_eff, if_addr_eff;
  logic [1:0]        ls_len_eff, wr_idx;
  logic              ls_rw_eff;
  logic [DATA_W-1:0] ls_data_eff;

  logic              seq_start, seq_abort, seq_step, seq_last_addr, seq_last_cap;
  logic [ADDR_W-1:0] seq_addr_in, seq_addr;
  logic [1:0]        seq_last_in, seq_cnt;
  logic [DATA_W-1:0] seq_data;

  mem_byte_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_seq (
    .clk        (clk),
    .rst        (rst),
    .start      (seq_start),
    .abort      (seq_abort),
    .step       (seq_step),
    .start_addr (seq_addr_in),
    .start_last (seq_last_in),
    .din        (mem_din),
    .addr       (seq_addr),
    .cnt        (seq_cnt),
    .last_addr  (seq_last_addr),
    .last_cap   (seq_last_cap),
    .asm_data   (seq_data)
  );

  // A request arriving with nothing pending is used directly so it can be granted at its latch edge.
  always_comb begin
    ls_in_flight = (state_q == LS_RD) || (state_q == LS_WR);
    ls_accept    = dataEn && !pend_ls_q && !ls_in_flight;
    if_accept    = ifEn && !clr && !pend_if_q && (state_q != IF_RD);
    ls_req       = pend_ls_q || ls_accept;
    if_req       = (pend_if_q && !clr) || if_accept;
    ls_addr_eff  = pend_ls_q ? ls_addr_q : dataAddr;
    ls_len_eff   = pend_ls_q ? ls_len_q  : LSlen;
    ls_rw_eff    = pend_ls_q ? ls_rw_q   : LSRW;
    ls_data_eff  = pend_ls_q ? ls_data_q : Sdata;
    if_addr_eff  = pend_if_q ? if_addr_q : ifAddr;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ls_req) state_d = (ls_rw_eff == RW_WRITE) ? LS_WR : LS_RD;
        else if (if_req) state_d = IF_RD;
      end
      LS_RD: if (seq_last_cap) state_d = IDLE;
      LS_WR: if (seq_last_addr) state_d = IDLE;
      IF_RD: if (clr || seq_last_cap) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pend_ls_d   = ls_req;
    pend_if_d   = if_req;
    ls_addr_d   = ls_accept ? dataAddr : ls_addr_q;
    ls_len_d    = ls_accept ? LSlen    : ls_len_q;
    ls_rw_d     = ls_accept ? LSRW     : ls_rw_q;
    ls_data_d   = ls_accept ? Sdata    : ls_data_q;
    if_addr_d   = if_accept ? ifAddr   : if_addr_q;

    seq_start   = DIS;
    seq_abort   = (state_q == IF_RD) && clr;
    seq_step    = (state_q != IDLE);
    seq_addr_in = ls_addr_eff;
    seq_last_in = ls_len_eff;
    wr_idx      = seq_cnt + 2'd1;

    if_out_en_d = DIS;
    l_out_en_d  = DIS;
    if_data_d   = if_data_q;
    ldata_d     = ldata_q;
    mem_wr_d    = DIS;
    mem_dout_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (ls_req) begin
          seq_start = EN;
          pend_ls_d = DIS;
          if (ls_rw_eff == RW_WRITE) begin
            mem_wr_d   = EN;
            mem_dout_d = ls_data_eff[7:0];
          end
        end else if (if_req) begin
          seq_start   = EN;
          seq_addr_in = if_addr_eff;
          seq_last_in = LEN_WORD;
          pend_if_d   = DIS;
        end
      end
      LS_RD: begin
        if (seq_last_cap) begin
          l_out_en_d = EN;
          ldata_d    = seq_data;
        end
      end
      LS_WR: begin
        if (seq_last_addr) begin
          l_out_en_d = EN;
        end else begin
          mem_wr_d   = EN;
          mem_dout_d = ls_data_q[{wr_idx, 3'b000} +: 8];
        end
      end
      IF_RD: begin
        if (!clr && seq_last_cap) begin
          if_out_en_d = EN;
          if_data_d   = seq_data;
        end
      end
      default: ;
    endcase

    ls_free_d = !(pend_ls_d || (state_d == LS_RD) || (state_d == LS_WR));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_if_q   <= DIS;
      pend_ls_q   <= DIS;
      if_addr_q   <= '0;
      ls_addr_q   <= '0;
      ls_len_q    <= '0;
      ls_rw_q     <= RW_READ;
      ls_data_q   <= '0;
      if_out_en_q <= DIS;
      l_out_en_q  <= DIS;
      if_data_q   <= '0;
      ldata_q     <= '0;
      ls_free_q   <= EN;
      mem_wr_q    <= DIS;
      mem_dout_q  <= '0;
    end else begin
      state_q     <= state_d;
      pend_if_q   <= pend_if_d;
      pend_ls_q   <= pend_ls_d;
      if_addr_q   <= if_addr_d;
      ls_addr_q   <= ls_addr_d;
      ls_len_q    <= ls_len_d;
      ls_rw_q     <= ls_rw_d;
      ls_data_q   <= ls_data_d;
      if_out_en_q <= if_out_en_d;
      l_out_en_q  <= l_out_en_d;
      if_data_q   <= if_data_d;
      ldata_q     <= ldata_d;
      ls_free_q   <= ls_free_d;
      mem_wr_q    <= mem_wr_d;
      mem_dout_q  <= mem_dout_d;
    end
  end

  assign ifOutEn  = if_out_en_q;
  assign ifData   = if_data_q;
  assign LOutEn   = l_out_en_q;
  assign Ldata    = ldata_q;
  assign LSfree   = ls_free_q;
  assign mem_a    = seq_addr;
  assign mem_wr   = mem_wr_q;
  assign mem_dout = mem_dout_q;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench for mem_arbiter_ctrl with a behavioural byte RAM (one-cycle read latency).
module tb_mem_arbiter_ctrl;

  logic        clk = 1'b0;
  logic        rst, clr, ifEn, dataEn, LSRW;
  logic [31:0] ifAddr, dataAddr, Sdata;
  logic [1:0]  LSlen;
  logic [7:0]  mem_din;
  logic        ifOutEn, LOutEn, LSfree, mem_wr;
  logic [31:0] ifData, Ldata, mem_a;
  logic [7:0]  mem_dout;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  logic [7:0] ram [0:4095];

  mem_arbiter_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .ifEn(ifEn), .ifAddr(ifAddr), .ifOutEn(ifOutEn), .ifData(ifData),
    .dataEn(dataEn), .LSRW(LSRW), .dataAddr(dataAddr), .LSlen(LSlen), .Sdata(Sdata),
    .LOutEn(LOutEn), .Ldata(Ldata), .LSfree(LSfree),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  // Advance one cycle; the RAM write and registered read use the values driven during the cycle.
  task automatic tick;
    logic [31:0] a;
    logic        w;
    logic [7:0]  d;
    a = mem_a; w = mem_wr; d = mem_dout;
    @(posedge clk);
    #1;
    if (w) begin
      ram[a[11:0]] = d;
      wr_count++;
    end
    mem_din = ram[a[11:0]];
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a got %h exp %h", mem_a, 32'h0); end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got %b exp 0", mem_wr); end
    checks++; if (mem_dout !== 8'h0) begin errors++; $display("FAIL reset_mem_dout got %h exp 00", mem_dout); end
    checks++; if (LSfree !== 1'b1) begin errors++; $display("FAIL reset_lsfree got %b exp 1", LSfree); end
    checks++; if (LOutEn !== 1'b0 || ifOutEn !== 1'b0) begin errors++; $display("FAIL reset_outen got %b%b exp 00", LOutEn, ifOutEn); end
    checks++; if (Ldata !== 32'h0 || ifData !== 32'h0) begin errors++; $display("FAIL reset_data got %h %h exp 0 0", Ldata, ifData); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_lw;
    logic [31:0] exp_a;
    ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
    dataEn = 1'b1; LSRW = 1'b0; dataAddr = 32'h100; LSlen = 2'b11;
    tick;
    dataEn = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      exp_a = (k <= 4) ? 32'h100 + 32'(k - 1) : 32'h0;
      checks++; if (mem_a !== exp_a) begin errors++; $display("FAIL lw_addr T+%0d got %h exp %h", k, mem_a, exp_a); end
      checks++; if (LSfree !== (k == 6)) begin errors++; $display("FAIL lw_lsfree T+%0d got %b exp %b", k, LSfree, (k == 6)); end
      checks++; if (LOutEn !== (k == 6)) begin errors++; $display("FAIL lw_outen T+%0d got %b exp %b", k, LOutEn, (k == 6)); end
      if (k == 6) begin
        checks++; if (Ldata !== 32'h44332211) begin errors++; $display("FAIL lw_data got %h exp 44332211", Ldata); end
      end
      if (k < 6) tick;
    end
    tick;
    checks++; if (LOutEn !== 1'b0) begin errors++; $display("FAIL lw_pulse_width got %b exp 0", LOutEn); end
  endtask

  task automatic test_sh;
    int w0;
    logic [31:0] exp_a;
    logic [7:0]  exp_d;
    ram[12'h020] = 8'h5A; ram[12'h021] = 8'h5A; ram[12'h022] = 8'h5A;
    w0 = wr_count;
    dataEn = 1'b1; LSRW = 1'b1; dataAddr = 32'h20; LSlen = 2'b01; Sdata = 32'hAABBCCDD;
    tick;
    dataEn = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      exp_a = (k == 1) ? 32'h20 : (k == 2) ? 32'h21 : 32'h0;
      exp_d = (k == 1) ? 8'hDD : (k == 2) ? 8'hCC : 8'h00;
      checks++; if (mem_wr !== (k <= 2)) begin errors++; $display("FAIL sh_wr T+%0d got %b exp %b", k, mem_wr, (k <= 2)); end
      checks++; if (mem_a !== exp_a || mem_dout !== exp_d) begin errors++; $display("FAIL sh_bus T+%0d got %h/%h exp %h/%h", k, mem_a, mem_dout, exp_a, exp_d); end
      checks++; if (LOutEn !== (k == 3)) begin errors++; $display("FAIL sh_outen T+%0d got %b exp %b", k, LOutEn, (k == 3)); end
      tick;
    end
    checks++; if (wr_count - w0 != 2) begin errors++; $display("FAIL sh_write_count got %0d exp 2", wr_count - w0); end
    checks++; if (ram[12'h020] !== 8'hDD || ram[12'h021] !== 8'hCC || ram[12'h022] !== 8'h5A) begin
      errors++; $display("FAIL sh_ram got %h %h %h exp dd cc 5a", ram[12'h020], ram[12'h021], ram[12'h022]); end
  endtask

  task automatic test_simultaneous;
    logic [31:0] exp_a;
    ram[12'h040] = 8'h80;
    ram[12'h000] = 8'h01; ram[12'h001] = 8'h02; ram[12'h002] = 8'h03; ram[12'h003] = 8'h04;
    ifEn = 1'b1; ifAddr = 32'h0;
    dataEn = 1'b1; LSRW = 1'b0; dataAddr = 32'h40; LSlen = 2'b00;
    tick;
    ifEn = 1'b0; dataEn = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      exp_a = (k == 1) ? 32'h40 : (k >= 4 && k <= 7) ? 32'(k - 4) : 32'h0;
      checks++; if (mem_a !== exp_a) begin errors++; $display("FAIL sim_addr T+%0d got %h exp %h", k, mem_a, exp_a); end
      checks++; if (LOutEn !== (k == 3) || ifOutEn !== (k == 9)) begin
        errors++; $display("FAIL sim_outen T+%0d got L%b I%b exp L%b I%b", k, LOutEn, ifOutEn, (k == 3), (k == 9)); end
      if (k == 3) begin
        checks++; if (Ldata !== 32'h00000080) begin errors++; $display("FAIL sim_ldata got %h exp 00000080", Ldata); end
      end
      if (k == 9) begin
        checks++; if (ifData !== 32'h04030201) begin errors++; $display("FAIL sim_ifdata got %h exp 04030201", ifData); end
      end
      if (k < 9) tick;
    end
    tick;
  endtask

  task automatic test_wrap;
    logic [31:0] exp_a;
    ram[12'hFFF] = 8'h12; ram[12'h000] = 8'h34;
    dataEn = 1'b1; LSRW = 1'b0; dataAddr = 32'hFFFF_FFFF; LSlen = 2'b01;
    tick;
    dataEn = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      exp_a = (k == 1) ? 32'hFFFF_FFFF : 32'h0;
      checks++; if (mem_a !== exp_a) begin errors++; $display("FAIL wrap_addr T+%0d got %h exp %h", k, mem_a, exp_a); end
      checks++; if (LOutEn !== (k == 4)) begin errors++; $display("FAIL wrap_outen T+%0d got %b exp %b", k, LOutEn, (k == 4)); end
      if (k == 4) begin
        checks++; if (Ldata !== 32'h00003412) begin errors++; $display("FAIL wrap_ldata got %h exp 00003412", Ldata); end
      end
      tick;
    end
  endtask

  task automatic test_clr_if;
    logic [31:0] exp_a;
    ram[12'h008] = 8'hA1; ram[12'h009] = 8'hB2; ram[12'h00A] = 8'hC3; ram[12'h00B] = 8'hD4;
    ifEn = 1'b1; ifAddr = 32'h10;
    tick;
    ifEn = 1'b0;
    tick;
    checks++; if (mem_a !== 32'h11) begin errors++; $display("FAIL clr_if_pre got %h exp 00000011", mem_a); end
    tick;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    for (int k = 4; k <= 8; k++) begin
      checks++; if (mem_a !== 32'h0 || ifOutEn !== 1'b0) begin
        errors++; $display("FAIL clr_if_abort T+%0d got %h/%b exp 0/0", k, mem_a, ifOutEn); end
      tick;
    end
    ifEn = 1'b1; ifAddr = 32'h8;
    tick;
    ifEn = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      exp_a = (k <= 4) ? 32'h8 + 32'(k - 1) : 32'h0;
      checks++; if (mem_a !== exp_a) begin errors++; $display("FAIL clr_if_next_addr T+%0d got %h exp %h", k, mem_a, exp_a); end
      checks++; if (ifOutEn !== (k == 6)) begin errors++; $display("FAIL clr_if_next_outen T+%0d got %b exp %b", k, ifOutEn, (k == 6)); end
      if (k == 6) begin
        checks++; if (ifData !== 32'hD4C3B2A1) begin errors++; $display("FAIL clr_if_next_data got %h exp d4c3b2a1", ifData); end
      end
      tick;
    end
  endtask

  task automatic test_clr_sw;
    int w0;
    logic [31:0] exp_a;
    w0 = wr_count;
    dataEn = 1'b1; LSRW = 1'b1; dataAddr = 32'h200; LSlen = 2'b11; Sdata = 32'h11223344;
    tick;
    dataEn = 1'b0;
    ifEn = 1'b1; ifAddr = 32'h300;
    checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h200 || mem_dout !== 8'h44) begin
      errors++; $display("FAIL clr_sw_first got %b/%h/%h exp 1/00000200/44", mem_wr, mem_a, mem_dout); end
    tick;
    ifEn = 1'b0;
    clr = 1'b1;
    checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h201 || mem_dout !== 8'h33) begin
      errors++; $display("FAIL clr_sw_second got %b/%h/%h exp 1/00000201/33", mem_wr, mem_a, mem_dout); end
    tick;
    clr = 1'b0;
    for (int k = 3; k <= 12; k++) begin
      exp_a = (k <= 4) ? 32'h200 + 32'(k - 1) : 32'h0;
      checks++; if (mem_wr !== (k <= 4) || mem_a !== exp_a) begin
        errors++; $display("FAIL clr_sw_bus T+%0d got %b/%h exp %b/%h", k, mem_wr, mem_a, (k <= 4), exp_a); end
      checks++; if (LOutEn !== (k == 5) || ifOutEn !== 1'b0) begin
        errors++; $display("FAIL clr_sw_outen T+%0d got L%b I%b exp L%b I0", k, LOutEn, ifOutEn, (k == 5)); end
      tick;
    end
    checks++; if (wr_count - w0 != 4) begin errors++; $display("FAIL clr_sw_write_count got %0d exp 4", wr_count - w0); end
    checks++; if (ram[12'h200] !== 8'h44 || ram[12'h203] !== 8'h11) begin
      errors++; $display("FAIL clr_sw_ram got %h %h exp 44 11", ram[12'h200], ram[12'h203]); end
  endtask

  task automatic test_rst_mid;
    dataEn = 1'b1; LSRW = 1'b0; dataAddr = 32'h100; LSlen = 2'b11;
    tick;
    dataEn = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++; if (mem_a !== 32'h0 || mem_wr !== 1'b0 || mem_dout !== 8'h0) begin
      errors++; $display("FAIL rst_mid_bus got %h/%b/%h exp 0/0/0", mem_a, mem_wr, mem_dout); end
    checks++; if (LSfree !== 1'b1 || LOutEn !== 1'b0 || ifOutEn !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ctrl got F%b L%b I%b exp F1 L0 I0", LSfree, LOutEn, ifOutEn); end
    checks++; if (Ldata !== 32'h0 || ifData !== 32'h0) begin
      errors++; $display("FAIL rst_mid_data got %h %h exp 0 0", Ldata, ifData); end
    for (int k = 0; k < 5; k++) begin
      tick;
      checks++; if (LOutEn !== 1'b0 || mem_a !== 32'h0) begin
        errors++; $display("FAIL rst_mid_quiet +%0d got L%b %h exp L0 0", k, LOutEn, mem_a); end
    end
    ram[12'h104] = 8'h55; ram[12'h105] = 8'h66; ram[12'h106] = 8'h77; ram[12'h107] = 8'h88;
    dataEn = 1'b1; dataAddr = 32'h104;
    tick;
    dataEn = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      checks++; if (LOutEn !== (k == 6)) begin errors++; $display("FAIL rst_mid_lw_outen T+%0d got %b exp %b", k, LOutEn, (k == 6)); end
      if (k == 6) begin
        checks++; if (Ldata !== 32'h88776655) begin errors++; $display("FAIL rst_mid_lw_data got %h exp 88776655", Ldata); end
      end
      tick;
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    mem_din = 8'h00;
    rst = 1'b1; clr = 1'b0; ifEn = 1'b0; dataEn = 1'b0; LSRW = 1'b0;
    ifAddr = '0; dataAddr = '0; LSlen = 2'b00; Sdata = '0;
    test_reset;
    test_lw;
    test_sh;
    test_simultaneous;
    test_wrap;
    test_clr_if;
    test_clr_sw;
    test_rst_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_ctrl.md
Name: mem_arbiter_ctrl

Overview:
- Shares the single byte-wide RAM port between instruction fetch (IF) and the load/store unit (LS).
- Latches single-cycle request pulses from both requesters, arbitrates between them, and sequences each 1/2/4-byte access byte by byte.
- Returns assembled read data, or a store-done pulse, to the requester.
- Sits between fetch/LS and the RAM.

Parameters:
- ADDR_W, 32, address width of requests and RAM address.
- DATA_W, 32, requester data width, a multiple of 8.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- clr  in  1  flush (mispredict); kills IF work only.
- ifEn  in  1  one-cycle IF request pulse, always a 4-byte read.
- ifAddr  in  ADDR_W  IF address.
- ifOutEn  out  1  one-cycle IF data-valid pulse.
- ifData  out  DATA_W  fetched word, little-endian.
- dataEn  in  1  one-cycle LS request pulse.
- LSRW  in  1  0 = read, 1 = write.
- dataAddr  in  ADDR_W  LS address.
- LSlen  in  2  byte count minus 1 (00 = byte, 01 = half, 11 = word).
- Sdata  in  DATA_W  store data; low bytes used.
- LOutEn  out  1  one-cycle LS completion pulse, for reads and writes.
- Ldata  out  DATA_W  load data, zero-extended; valid with LOutEn.
- LSfree  out  1  high when there is no LS request pending or in flight.
- mem_din  in  8  RAM read byte.
- mem_dout  out  8  RAM write byte.
- mem_a  out  ADDR_W  RAM address.
- mem_wr  out  1  RAM write strobe.

Behaviour:
- Reset:
  - State IDLE; pending flags cleared.
  - ifOutEn = 0, ifData = 0, LOutEn = 0, Ldata = 0, LSfree = 1, mem_a = 0, mem_dout = 0, mem_wr = 0.
  - A reset mid-access abandons it silently; no completion pulse.
- All outputs are registered.
- RAM timing: the read byte for the address driven in cycle N appears on mem_din in cycle N+1. A write takes effect in the cycle mem_wr = 1.
- Request latching:
  - ifEn and dataEn are captured into pendIF / pendLS together with their address, length, R/W and data.
  - Both may arrive in the same cycle.
  - A second request from a requester that already has one pending or in flight is ignored; upstream never does this.
- LSfree falls in the cycle after dataEn and rises in the cycle LOutEn = 1.
- States:
  - IDLE: grant pendLS first, otherwise pendIF.
    - LS read -> LS_RD, LS write -> LS_WR, IF -> IF_RD.
    - The grant is taken at the edge; the first address is driven the next cycle.
    - A request arriving in IDLE with nothing pending is granted at the edge that latches it.
  - LS_RD / IF_RD:
    - Byte counter k = 0 .. n-1, with n = LSlen+1 (4 for IF).
    - mem_a = base + k; the address advances every cycle.
    - The byte for k is captured one cycle later into byte lane k.
    - After the last capture, pulse LOutEn/ifOutEn for one cycle with the assembled data; unused upper bytes are 0. Return to IDLE.
  - LS_WR:
    - mem_a = base + k, mem_dout = Sdata byte k, mem_wr = 1 for n consecutive cycles.
    - LOutEn pulses in the cycle after the last write. Return to IDLE.
- Latency, with the request in cycle T and the controller idle:
  - Read of n bytes: addresses in T+1 .. T+n, completion pulse in T+n+2 (LW/IF: T+6, LB: T+3).
  - Write of n bytes: writes in T+1 .. T+n, completion pulse in T+n+1 (SW: T+5).
- Back-to-back: arbitration happens in the completion cycle; the next request's first address is driven the cycle after.
- Address arithmetic wraps modulo 2^ADDR_W.
- Outside an access: mem_wr = 0, mem_a = 0, mem_dout = 0.
- clr:
  - Clears pendIF.
  - If in IF_RD, aborts at that edge: no ifOutEn, next state IDLE, mem_wr stays 0.
  - ifEn in the same cycle as clr is dropped.
  - LS state and pendLS are never affected; stores always complete.
- Priority is fixed LS-over-IF. IF starvation is bounded because LS issues at most one outstanding request.

Decomposition:
- Shared package holds:
  - LSlen codes (BYTE = 00, HALF = 01, WORD = 11).
  - Read/Write encodings.
  - The state enumeration (IDLE, IF_RD, LS_RD, LS_WR).
  - Enable/Disable constants.
- One natural sub-module, mem_byte_seq: the byte counter, address incrementer, lane-assembly shift register and last-byte detect. The arbiter FSM instantiates it once.

Test Plan:
- LW: dataEn at T, addr 0x100, RAM bytes 11,22,33,44 -> mem_a 0x100..0x103 in T+1..T+4; LOutEn at T+6 with Ldata = 0x44332211; LSfree low T+1..T+5.
- SH: Sdata 0xAABBCCDD at 0x20 -> mem_wr = 1 in T+1 (0x20, DD) and T+2 (0x21, CC); LOutEn at T+3; no other writes.
- Simultaneous ifEn (0x0) and LB (0x40, byte 0x80) in T -> LS first: LOutEn at T+3 with Ldata = 0x00000080. IF addresses start at T+4; ifOutEn at T+9.
- clr during IF_RD after the second byte -> no ifOutEn; mem_a returns to 0; a following ifEn at 0x8 completes normally after 6 cycles.
- clr while an SW is in flight with pendIF set -> all 4 bytes written, LOutEn pulses, pendIF dropped, no IF access.
- rst asserted mid LW -> next cycle all outputs at reset values, LSfree = 1, no LOutEn; a new LW completes with correct data.
